// File: rtl/bf_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bf_io_pkg
// Purpose  : Shared character constants and output-side state encoding for
//            the brainfuck CPU output path.
// Contents : BYTE_W, CHAR_LF, CHAR_CR, crlf_state_t.
// Revision : 1.0  initial release
// ============================================================================
package bf_io_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;
  localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;

  // PASS    : head byte is presented (LF is shown as CR first)
  // LF_PEND : CR already emitted for the head LF, LF itself now shown
  typedef enum logic {
    PASS    = 1'b0,
    LF_PEND = 1'b1
  } crlf_state_t;

endpackage : bf_io_pkg
`default_nettype wire

// File: rtl/bf_crlf_expander.sv
`default_nettype none
// ============================================================================
// Module   : bf_crlf_expander
// Purpose  : Output-side LF -> CR+LF expansion. Sits between the FIFO head
//            read and the downstream handshake. An LF at the head is emitted
//            twice (first as CR, then as LF) but popped from storage once.
// Ports    : clk, rst_n      clock, async active-low reset
//            clear           synchronous flush, forces PASS
//            head_data/valid FIFO head byte and non-empty flag
//            out_data/valid  presented character to the downstream stage
//            out_ready       downstream consumes
//            pop             advance the FIFO read pointer this cycle
// Config   : instantiated by bf_out_fifo only when BF_OUT_CRLF_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module bf_crlf_expander
  import bf_io_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [BYTE_W-1:0] head_data,
  input  logic              head_valid,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              pop
);

  crlf_state_t state_q;
  crlf_state_t state_d;
  logic        hs;

  always_comb begin
    hs        = head_valid && out_ready;
    state_d   = state_q;
    out_data  = head_data;
    out_valid = head_valid;
    pop       = 1'b0;
    case (state_q)
      PASS: begin
        if (head_data == CHAR_LF) begin
          // Emit CR first; the LF stays stored until the second beat.
          out_data = CHAR_CR;
          if (hs) state_d = LF_PEND;
        end else begin
          pop = hs;
        end
      end
      LF_PEND: begin
        out_data = CHAR_LF;
        pop      = hs;
        if (hs) state_d = PASS;
      end
      default: state_d = PASS;
    endcase
    if (clear) state_d = PASS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PASS;
    end else begin
      state_q <= state_d;
    end
  end

endmodule : bf_crlf_expander
`default_nettype wire

// File: rtl/bf_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bf_out_fifo
// Purpose  : First-word-fall-through byte FIFO between the CPU output port
//            and the serial line-display stage. Stalls the CPU when full.
// Ports    : clk, rst_n            clock, async active-low reset
//            clear                 synchronous flush (pointers, level, CRLF)
//            in_data/valid/ready   CPU side, valid/ready handshake
//            out_data/valid/ready  downstream side, valid/ready handshake
//            level                 stored bytes, 0..DEPTH
// Params   : DEPTH (power of two, >= 2), WIDTH (8 only)
// Config   : `define BF_OUT_CRLF_EN to expand LF into CR+LF on output.
// Revision : 1.0  initial release
// ============================================================================
module bf_out_fifo
  import bf_io_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                LVL_W    = PTR_W + 1;
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_data;
  logic             head_valid;

  // Status is decoded from the level register only, so in_ready never
  // depends on in_valid and a full FIFO refuses even when popping.
  assign full       = (level_q == FULL_LVL);
  assign empty      = (level_q == '0);
  assign in_ready   = !full && !clear;
  assign push       = in_valid && in_ready;
  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = !empty;
  assign level      = level_q;

`ifdef BF_OUT_CRLF_EN
  bf_crlf_expander u_crlf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .head_data  (head_data),
    .head_valid (head_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pop        (pop)
  );
`else
  assign out_data  = head_data;
  assign out_valid = head_valid;
  assign pop       = head_valid && out_ready;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage has no reset; contents survive clear and are never read while
  // the level says the slot is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule : bf_out_fifo
`default_nettype wire

// File: tb/tb_bf_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_out_fifo
// Purpose  : Directed self-checking bench for bf_out_fifo (DEPTH = 16).
//            Expectations for the LF test follow BF_OUT_CRLF_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_bf_out_fifo;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;

`ifdef BF_OUT_CRLF_EN
  localparam int N_LF = 4;
  logic [7:0] lf_data [N_LF] = '{8'h48, 8'h0D, 8'h0A, 8'h49};
  logic [4:0] lf_lvl  [N_LF] = '{5'd3, 5'd2, 5'd2, 5'd1};
`else
  localparam int N_LF = 3;
  logic [7:0] lf_data [N_LF] = '{8'h48, 8'h0A, 8'h49};
  logic [4:0] lf_lvl  [N_LF] = '{5'd3, 5'd2, 5'd1};
`endif

  bf_out_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Push one byte on the coming rising edge (inputs set at the falling edge).
  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  initial begin
    int wr_seq;
    int rd_seq;

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // ---------------- reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level",     level,     0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- three bytes held, then drained
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("abc_level",   level,     3);
    chk("abc_valid",   out_valid, 1);
    chk("abc_head",    out_data,  8'h41);
    @(negedge clk);
    #1;
    chk("abc_hold",    out_data,  8'h41);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("abc_drain", out_data, 32'h41 + 32'(i));
      @(negedge clk);
      #1;
    end
    chk("abc_empty_valid", out_valid, 0);
    chk("abc_empty_level", level,     0);
    out_ready = 1'b0;

    // ---------------- fill to full, 17th byte waits for a pop
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    #1;
    chk("full_ready", in_ready, 0);
    chk("full_level", level,    16);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("full_pop_cycle_ready", in_ready, 0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("after_pop_ready", in_ready, 1);
    chk("after_pop_level", level,    15);
    chk("after_pop_head",  out_data, 8'h11);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("refill_level", level,    16);
    chk("refill_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("full_drain", out_data, (i < 15) ? 32'h11 + 32'(i) : 32'hAA);
      @(negedge clk);
      #1;
    end
    chk("full_drain_empty", out_valid, 0);
    out_ready = 1'b0;

    // ---------------- steady push+pop at level 5, pointers wrap
    wr_seq = 0;
    rd_seq = 0;
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h30 + 8'(wr_seq));
      wr_seq++;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 8'h30 + 8'(wr_seq);
      wr_seq++;
      out_ready = 1'b1;
      #1;
      chk("steady_data",  out_data, 32'((8'h30 + 8'(rd_seq))));
      chk("steady_level", level,    5);
      rd_seq++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("steady_end_level", level,    5);
    chk("steady_end_head",  out_data, 32'((8'h30 + 8'(rd_seq))));

    // ---------------- clear at level 7 with a push offered
    push_byte(8'hE0);
    push_byte(8'hE1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_clear_level", level, 7);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    chk("clear_ready_low", in_ready, 0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clear_level", level,     0);
    chk("clear_valid", out_valid, 0);
    chk("clear_ready", in_ready,  1);
    push_byte(8'h77);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_clear_head",  out_data, 8'h77);
    chk("post_clear_level", level,    1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("post_clear_empty", out_valid, 0);

    // ---------------- LF handling
    push_byte(8'h48);
    push_byte(8'h0A);
    push_byte(8'h49);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N_LF; i++) begin
      #1;
      chk("lf_data",  out_data, lf_data[i]);
      chk("lf_level", level,    lf_lvl[i]);
      @(negedge clk);
    end
    #1;
    chk("lf_empty_valid", out_valid, 0);
    chk("lf_empty_level", level,     0);
    out_ready = 1'b0;

    // ---------------- asynchronous reset mid-drain
    for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("pre_rst_level", level, 4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", level,     0);
    chk("mid_rst_ready", in_ready,  1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    push_byte(8'h55);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_rst_head",  out_data,  8'h55);
    chk("post_rst_level", level,     1);
    chk("post_rst_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("post_rst_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bf_out_fifo
`default_nettype wire

// File: doc/bf_out_fifo.md
# bf_out_fifo

Byte FIFO between the brainfuck CPU output port (`.` instruction) and the serial line-display stage. Accepts characters from the CPU with a valid/ready handshake, stalling the CPU when full, and presents them first-word-fall-through to the downstream serial stage. Optionally expands LF into CR+LF for terminal display.

## Interface
- `DEPTH`, 16: storage entries; power of two, ≥ 2.
- `WIDTH`, 8: data width; only 8 is supported.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clear`  in  1  synchronous flush.
- `in_data`  in  8  character from the CPU.
- `in_valid`  in  1  CPU offers `in_data`.
- `in_ready`  out  1  FIFO accepts; CPU stalls while low.
- `out_data`  out  8  head character.
- `out_valid`  out  1  head valid.
- `out_ready`  in  1  downstream consumes.
- `level`  out  $clog2(DEPTH)+1  stored entries, 0..DEPTH.

## Operation
- Push: `in_valid && in_ready` at a rising edge. Write to `mem[wr_ptr]`, then increment `wr_ptr`.
- `in_ready = !full && !clear`. It is decoded from registers and does not depend combinationally on `in_valid`.
- Pop: `out_valid && out_ready` at a rising edge. `rd_ptr` increments, except on CR-insert beats (see Configuration).
- `out_valid = !empty`. `out_data` is an asynchronous read of `mem[rd_ptr]`.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` is a separate up/down counter: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full is `level == DEPTH`:
  - push refused, even if a pop occurs in the same cycle;
  - no pass-through while full.
- Empty is `level == 0`:
  - `out_valid` is low;
  - a push in that cycle does not appear on the output until the next cycle (no bypass).
- Simultaneous push and pop when partially full: both occur and `level` is unchanged.
- `clear` has priority over push and pop. It zeroes the pointers, `level`, and the CRLF state. Memory contents are left unchanged.
- Stability: while `out_valid && !out_ready`, `out_data` stays stable. The upstream side must hold `in_data` while `in_valid && !in_ready`.
- Reset values: `in_ready` = 1, `out_valid` = 0, `level` = 0, `out_data` = don't-care (mem unread). Both pointers are 0 and the CRLF state is PASS.
- Reset mid-operation discards all stored bytes immediately (asynchronously).

## Timing
- Push at edge N → `out_valid` is high and `out_data` shows the byte after edge N, when the FIFO was empty.
- Latency is 1 cycle in to out; throughput is 1 byte/cycle on each side.
- `clear` asserted before edge N → `in_ready` is low during that cycle. After edge N, `out_valid` = 0 and `level` = 0.
- `in_ready` and `out_valid` can change only after a clock edge or reset. `in_ready` is also forced low combinationally by `clear`.

## Configuration
- Macro `BF_OUT_CRLF_EN`.
- With the macro:
  - Output state machine with two states, PASS and LF_PEND.
  - In PASS with head = 0x0A: `out_data` = 0x0D. The handshake moves to LF_PEND with no pop.
  - In LF_PEND: `out_data` = 0x0A. The handshake pops and returns to PASS.
  - All other bytes pass unchanged in PASS.
  - `clear` or reset forces PASS.
- Without the macro: there is no state machine, bytes pass unmodified, and one handshake equals one pop.
- `level` always counts stored bytes, never emitted bytes.

## Structure
- Package `bf_io_pkg` holds:
  - `CHAR_LF` = 8'h0A and `CHAR_CR` = 8'h0D;
  - `crlf_state_t` enum {PASS, LF_PEND};
  - `BYTE_W` = 8.
- Sub-module `bf_crlf_expander` holds the output-side state machine. It sits between the head read and the `out_*` ports and is instantiated only under `BF_OUT_CRLF_EN`.
- Storage, pointers and `level` stay inline.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 with `out_ready` = 0:
  - `level` = 3 and `out_data` = 0x41 held stable;
  - raising `out_ready` drains 0x41, 0x42, 0x43 on 3 consecutive cycles, then `out_valid` = 0.
- With DEPTH = 16, push 16 bytes → `in_ready` = 0 and `level` = 16. A 17th byte held on `in_valid` is accepted only one cycle after the first pop.
- FIFO at level 5, push and pop every cycle for 40 cycles → `level` stays 5, the output sequence matches input order, and the pointers wrap cleanly.
- Level 7, assert `clear` for 1 cycle with `in_valid` = 1 → the byte is not stored, `level` = 0, and `out_valid` = 0 on the next cycle.
- `BF_OUT_CRLF_EN`: push 0x48, 0x0A, 0x49 → output is 0x48, 0x0D, 0x0A, 0x49. `level` decrements only on 0x48, 0x0A and 0x49. Without the macro the output is 0x48, 0x0A, 0x49.
- Deassert `rst_n` mid-drain at level 4 → outputs return to reset values immediately. After release, a push of 0x55 reappears as the only byte.
